// File: rtl/param_accumulator.sv
// Run-triggered accumulator: one load/add/subtract per Run press, optional saturation,
// carry/borrow flag, one-cycle Done pulse and a wrapping operation counter.
module param_accumulator #(
    parameter int WIDTH     = 16,
    parameter int IN_WIDTH  = 10,
    parameter int SATURATE  = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Clear,
    input  logic                 Run,
    input  logic [1:0]           Mode,
    input  logic [IN_WIDTH-1:0]  Data_In,
    output logic [WIDTH-1:0]     Acc,
    output logic                 Carry,
    output logic                 Done,
    output logic                 Busy,
    output logic [CNT_WIDTH-1:0] Op_Count
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        EXEC         = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 carry_q, carry_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]     operand;
    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;

    // Top bit of the extended result is the carry (add) or borrow (subtract).
    function automatic logic [WIDTH-1:0] clamp_result(input logic [WIDTH:0] r, input logic is_sub);
        if (SATURATE != 0 && r[WIDTH]) begin
            return is_sub ? '0 : '1;
        end
        return r[WIDTH-1:0];
    endfunction

    assign operand = WIDTH'(Data_In);
    assign sum_w   = {1'b0, acc_q} + {1'b0, operand};
    assign diff_w  = {1'b0, acc_q} - {1'b0, operand};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE:         if (Run) state_d = EXEC;
            EXEC:         state_d = WAIT_RELEASE;
            WAIT_RELEASE: if (!Run) state_d = IDLE;
            default:      state_d = IDLE;
        endcase

        // Clear discards an operation that lands on the same EXEC cycle.
        if (Clear) begin
            acc_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == EXEC) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            case (Mode)
                MODE_LOAD: begin
                    acc_d   = operand;
                    carry_d = 1'b0;
                end
                MODE_ADD: begin
                    acc_d   = clamp_result(sum_w, 1'b0);
                    carry_d = sum_w[WIDTH];
                end
                MODE_SUB: begin
                    acc_d   = clamp_result(diff_w, 1'b1);
                    carry_d = diff_w[WIDTH];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Acc      = acc_q;
    assign Carry    = carry_q;
    assign Done     = done_q;
    assign Op_Count = cnt_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_param_accumulator.sv
// Directed bench: a wrap-around and a saturating accumulator share clock, Run, Clear and Reset
// but take their own Mode/Data_In so each can be steered to the boundary values.
module tb_param_accumulator;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        run;
    logic [1:0]  mode_w, mode_s;
    logic [9:0]  data_w, data_s;
    logic [15:0] acc_w, acc_s;
    logic        carry_w, carry_s;
    logic        done_w, done_s;
    logic        busy_w, busy_s;
    logic [7:0]  cnt_w, cnt_s;

    int tests_run    = 0;
    int tests_failed = 0;
    int busy_cycles;
    int done_pulses;

    param_accumulator #(.WIDTH(16), .IN_WIDTH(10), .SATURATE(0), .CNT_WIDTH(8)) u_wrap (
        .Clk(clk), .Reset(rst), .Clear(clr), .Run(run), .Mode(mode_w), .Data_In(data_w),
        .Acc(acc_w), .Carry(carry_w), .Done(done_w), .Busy(busy_w), .Op_Count(cnt_w)
    );

    param_accumulator #(.WIDTH(16), .IN_WIDTH(10), .SATURATE(1), .CNT_WIDTH(8)) u_sat (
        .Clk(clk), .Reset(rst), .Clear(clr), .Run(run), .Mode(mode_s), .Data_In(data_s),
        .Acc(acc_s), .Carry(carry_s), .Done(done_s), .Busy(busy_s), .Op_Count(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One Run press: high for the IDLE->EXEC edge, then released; returns in IDLE.
    task automatic press(input logic [1:0] mw, input logic [9:0] dw,
                         input logic [1:0] ms, input logic [9:0] ds);
        mode_w = mw; data_w = dw; mode_s = ms; data_s = ds;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_both(input string tag, input logic [15:0] aw, input logic cw,
                              input logic [15:0] as, input logic cs, input logic [7:0] n);
        check({tag, " acc_w"}, 32'(acc_w), 32'(aw));
        check({tag, " carry_w"}, 32'(carry_w), 32'(cw));
        check({tag, " acc_s"}, 32'(acc_s), 32'(as));
        check({tag, " carry_s"}, 32'(carry_s), 32'(cs));
        check({tag, " cnt"}, 32'(cnt_w), 32'(n));
        check({tag, " cnt_s"}, 32'(cnt_s), 32'(n));
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; run = 1'b0;
        mode_w = 2'b00; mode_s = 2'b00; data_w = '0; data_s = '0;
        tick();
        tick();
        rst = 1'b0;
        check_both("reset", 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);
        check("reset done", 32'(done_w | done_s), 32'd0);
        check("reset busy", 32'(busy_w | busy_s), 32'd0);

        // Load 0x3FF with a one-cycle Run pulse, checking Done timing.
        mode_w = 2'b00; data_w = 10'h3FF; mode_s = 2'b00; data_s = 10'h3FF;
        run = 1'b1;
        tick();
        check("load exec done", 32'(done_w), 32'd0);
        check("load exec busy", 32'(busy_w), 32'd1);
        run = 1'b0;
        tick();
        check("load k1 done_w", 32'(done_w), 32'd1);
        check("load k1 done_s", 32'(done_s), 32'd1);
        check_both("load", 16'h03FF, 1'b0, 16'h03FF, 1'b0, 8'd1);
        tick();
        check("load k2 done", 32'(done_w), 32'd0);
        check("load k2 busy", 32'(busy_w), 32'd0);

        // Held Run for 20 cycles commits exactly one add.
        mode_w = 2'b01; data_w = 10'h001; mode_s = 2'b01; data_s = 10'h001;
        run = 1'b1;
        busy_cycles = 0;
        done_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy_w) busy_cycles++;
            if (done_w) done_pulses++;
        end
        check("hold busy cycles", 32'(busy_cycles), 32'd20);
        check("hold done pulses", 32'(done_pulses), 32'd1);
        run = 1'b0;
        check("release cycle busy", 32'(busy_w), 32'd1);
        tick();
        check("after release busy", 32'(busy_w), 32'd0);
        check_both("hold add", 16'h0400, 1'b0, 16'h0400, 1'b0, 8'd2);

        // Drive both accumulators to 0xFFFF by different routes.
        press(2'b00, 10'h000, 2'b00, 10'h000);
        for (int i = 0; i < 64; i++) press(2'b11, 10'h000, 2'b01, 10'h3FF);
        check_both("ramp", 16'h0000, 1'b0, 16'hFFC0, 1'b0, 8'd67);
        press(2'b10, 10'h001, 2'b01, 10'h3FF);
        check_both("to max", 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 8'd68);

        press(2'b01, 10'h002, 2'b01, 10'h002);
        check_both("add overflow", 16'h0001, 1'b1, 16'hFFFF, 1'b1, 8'd69);

        press(2'b00, 10'h005, 2'b00, 10'h005);
        check_both("load 5", 16'h0005, 1'b0, 16'h0005, 1'b0, 8'd70);
        press(2'b10, 10'h006, 2'b10, 10'h006);
        check_both("sub underflow", 16'hFFFF, 1'b1, 16'h0000, 1'b1, 8'd71);
        press(2'b11, 10'h3FF, 2'b11, 10'h3FF);
        check_both("noop", 16'hFFFF, 1'b1, 16'h0000, 1'b1, 8'd72);
        press(2'b00, 10'h010, 2'b00, 10'h010);
        press(2'b10, 10'h001, 2'b10, 10'h001);
        check_both("sub normal", 16'h000F, 1'b0, 16'h000F, 1'b0, 8'd74);

        // Clear on the EXEC cycle discards the add.
        mode_w = 2'b01; data_w = 10'h001; mode_s = 2'b01; data_s = 10'h001;
        run = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_both("clear exec", 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);
        check("clear exec done", 32'(done_w | done_s), 32'd0);
        check("clear exec busy", 32'(busy_w), 32'd1);
        tick();
        check("clear held busy", 32'(busy_w), 32'd1);
        check("clear held done", 32'(done_w), 32'd0);

        // Reset in WAIT_RELEASE with Run still held, then re-entry.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst wait busy", 32'(busy_w | busy_s), 32'd0);
        check_both("rst wait", 16'h0000, 1'b0, 16'h0000, 1'b0, 8'd0);
        tick();
        check("reenter busy", 32'(busy_w), 32'd1);
        tick();
        check("reenter done", 32'(done_w), 32'd1);
        check_both("reenter add", 16'h0001, 1'b0, 16'h0001, 1'b0, 8'd1);
        run = 1'b0;
        tick();
        tick();

        // Counter wrap: 256 commits since reset returns it to zero.
        for (int i = 0; i < 254; i++) press(2'b00, 10'h02A, 2'b00, 10'h02A);
        check_both("cnt 255", 16'h002A, 1'b0, 16'h002A, 1'b0, 8'hFF);
        press(2'b00, 10'h02A, 2'b00, 10'h02A);
        check_both("cnt wrap", 16'h002A, 1'b0, 16'h002A, 1'b0, 8'h00);
        check("cnt wrap busy", 32'(busy_w), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/param_accumulator.md
Name: param_accumulator

Overview:
- Parametrised successor to the lab switch-accumulator datapath.
- Each press of Run performs exactly one operation on a WIDTH-bit accumulator: load, add, or subtract of a zero-extended IN_WIDTH-bit operand.
- Adds selectable wrap/saturate arithmetic, a carry/borrow flag, a done pulse, and an operation counter.
- Sits between the debounced/inverted button logic and the hex/LED display drivers.

Parameters:
WIDTH, 16, accumulator width in bits (2..32)
IN_WIDTH, 10, operand width; must be <= WIDTH; zero-extended to WIDTH
SATURATE, 0, 0 = wrap-around arithmetic; 1 = clamp to all-ones on add carry, clamp to 0 on subtract borrow
CNT_WIDTH, 8, width of the operation counter

Ports:
Clk  input  1  system clock; all state changes on the rising edge
Reset  input  1  synchronous, active-high reset
Clear  input  1  synchronous clear of data registers (active-high level)
Run  input  1  active-high request level; already synchronised and inverted upstream
Mode  input  2  operation select: 00 load, 01 add, 10 subtract, 11 no-op
Data_In  input  IN_WIDTH  operand
Acc  output  WIDTH  accumulator value
Carry  output  1  carry (add) or borrow (subtract) of the last executed operation
Done  output  1  one-cycle pulse when an operation is committed
Busy  output  1  high in EXEC and WAIT_RELEASE
Op_Count  output  CNT_WIDTH  number of committed operations; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (highest priority): Acc=0, Carry=0, Done=0, Op_Count=0, state=IDLE. Reset takes effect the same cycle whether or not an operation is in progress.
- FSM states: IDLE, EXEC, WAIT_RELEASE.
  - IDLE: Run=1 -> EXEC; otherwise stay.
  - EXEC: lasts one cycle, always -> WAIT_RELEASE. Mode and Data_In are sampled on the EXEC cycle.
  - WAIT_RELEASE: Run=0 -> IDLE; otherwise stay. A held Run never retriggers.
- Latency: Run is first seen high at edge k (enter EXEC). Acc, Carry and Op_Count update, and Done=1, after edge k+1. Done is low again after edge k+2.
- Arithmetic: D = {zeros, Data_In}. Compute a WIDTH+1-bit result.
  - Load: Acc=D, Carry=0.
  - Add: {c, s} = Acc + D.
  - Subtract: {b, s} = Acc - D; b = 1 when Acc < D.
  - No-op: Acc and Carry unchanged. Done still pulses and Op_Count still increments.
  - SATURATE=0: Acc=s, Carry=c or b.
  - SATURATE=1: Acc = all-ones if add carry, 0 if subtract borrow, else s. Carry still reports c or b.
- Op_Count increments by 1 on each committed operation and wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Clear (priority below Reset):
  - Sets Acc=0, Carry=0, Op_Count=0; does not change FSM state.
  - If Clear coincides with the EXEC cycle, Clear wins: the operation is discarded, Done stays 0, Op_Count stays 0, and the FSM still moves to WAIT_RELEASE.
- Run dropping during EXEC has no effect; the operation completes.
- Busy = (state != IDLE), decoded from registered state.
- All outputs are registered except Busy.

Test Plan (WIDTH=16, IN_WIDTH=10, CNT_WIDTH=8 unless noted):
- Reset then Mode=00, Data_In=0x3FF, pulse Run 1 cycle -> Acc=0x03FF, Carry=0, Done high exactly one cycle at edge k+1, Op_Count=1.
- Acc=0x03FF, Mode=01, Data_In=0x001, hold Run 20 cycles -> exactly one add: Acc=0x0400, Op_Count=2, Busy high for all 20 cycles plus the release cycle.
- SATURATE=0: Acc=0xFFFF, add 0x002 -> Acc=0x0001, Carry=1. SATURATE=1, same stimulus -> Acc=0xFFFF, Carry=1.
- Acc=0x0005, Mode=10, Data_In=0x006 -> SATURATE=0: Acc=0xFFFF, Carry=1. SATURATE=1: Acc=0x0000, Carry=1. Then subtract 0x001 from 0x0010 -> Acc=0x000F, Carry=0.
- Assert Clear on the EXEC cycle of an add -> Acc=0, Op_Count=0, no Done pulse, FSM in WAIT_RELEASE until Run=0. Assert Reset while in WAIT_RELEASE with Run held -> next cycle IDLE, all outputs 0, and Run still high re-enters EXEC.
- 256 load presses -> Op_Count wraps to 0x00 on the 256th commit, with no other side effect.
